// File: rtl/tetris_pkg.sv
// Shared constants for the playfield and game logic: board size defaults,
// coordinate widths, board FSM state type and spawn position.
package tetris_pkg;

    localparam int COLS_DEF = 10;
    localparam int ROWS_DEF = 20;

    localparam int X_W = 4;
    localparam int Y_W = 5;

    localparam logic [X_W-1:0] SPAWN_X = 4'd4;
    localparam logic [Y_W-1:0] SPAWN_Y = 5'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } board_state_e;

endpackage

// File: rtl/tetris_board.sv
// Playfield storage with a bottom-up line-clear engine and a renderer row port.
// Optional macro TETRIS_BOARD_SCORE_EN adds a saturating total_lines counter.
module tetris_board
    import tetris_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [X_W-1:0]  board_rx,
    input  logic [Y_W-1:0]  board_ry,
    output logic            board_rdata,
    input  logic            board_we,
    input  logic [X_W-1:0]  board_wx,
    input  logic [Y_W-1:0]  board_wy,
    input  logic            board_wdata,
    input  logic            clear_start,
    output logic            clear_busy,
    output logic            clear_done,
    output logic [2:0]      lines_cleared,
`ifdef TETRIS_BOARD_SCORE_EN
    output logic [15:0]     total_lines,
`endif
    input  logic [Y_W-1:0]  vga_ry,
    output logic [COLS-1:0] vga_row
);

    logic [COLS-1:0] rows_q [ROWS];
    logic [COLS-1:0] rows_d [ROWS];
    board_state_e    state_q, state_d;
    logic [Y_W-1:0]  r_q, r_d;
    logic [Y_W-1:0]  k_q, k_d;
    logic [2:0]      count_q, count_d;
    logic [2:0]      lines_q, lines_d;
    logic            busy;
    logic            wr_ok;
    logic            row_r_full;

    assign busy       = (state_q == S_SCAN) || (state_q == S_SHIFT);
    assign clear_busy = busy;
    assign clear_done = (state_q == S_DONE);
    // Present the fresh count during the done pulse; the register holds it afterwards.
    assign lines_cleared = (state_q == S_DONE) ? count_q : lines_q;

    always_comb begin
        board_rdata = 1'b1;
        vga_row     = '0;
        row_r_full  = 1'b0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (board_ry == Y_W'(i) && int'(board_rx) < COLS) begin
                board_rdata = rows_q[i][board_rx];
            end
            if (vga_ry == Y_W'(i)) begin
                vga_row = rows_q[i];
            end
            if (r_q == Y_W'(i)) begin
                row_r_full = &rows_q[i];
            end
        end
    end

    assign wr_ok = board_we && !busy && int'(board_wx) < COLS && int'(board_wy) < ROWS;

    always_comb begin
        rows_d  = rows_q;
        state_d = state_q;
        r_d     = r_q;
        k_d     = k_q;
        count_d = count_q;
        lines_d = lines_q;

        if (wr_ok) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                if (board_wy == Y_W'(i)) begin
                    rows_d[i][board_wx] = board_wdata;
                end
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (clear_start) begin
                    r_d     = Y_W'(ROWS - 1);
                    count_d = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (row_r_full) begin
                    k_d     = r_q;
                    count_d = (count_q == 3'd7) ? count_q : count_q + 3'd1;
                    state_d = S_SHIFT;
                end else if (r_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    r_d = r_q - Y_W'(1);
                end
            end
            S_SHIFT: begin
                // r is left alone so the row that just received its upper neighbour is rescanned.
                if (k_q == '0) begin
                    rows_d[0] = '0;
                    state_d   = S_SCAN;
                end else begin
                    for (int unsigned i = 1; i < ROWS; i++) begin
                        if (k_q == Y_W'(i)) begin
                            rows_d[i] = rows_q[i-1];
                        end
                    end
                    k_d = k_q - Y_W'(1);
                end
            end
            S_DONE: begin
                lines_d = count_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                rows_q[i] <= '0;
            end
            state_q <= S_IDLE;
            r_q     <= '0;
            k_q     <= '0;
            count_q <= '0;
            lines_q <= '0;
        end else begin
            rows_q  <= rows_d;
            state_q <= state_d;
            r_q     <= r_d;
            k_q     <= k_d;
            count_q <= count_d;
            lines_q <= lines_d;
        end
    end

`ifdef TETRIS_BOARD_SCORE_EN
    logic [15:0] total_q, total_d;
    logic [16:0] total_sum;

    always_comb begin
        total_sum = {1'b0, total_q} + 17'(count_q);
        total_d   = total_q;
        if (state_q == S_DONE) begin
            total_d = total_sum[16] ? '1 : total_sum[15:0];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign total_lines = total_q;
`endif

endmodule
